// File: rtl/nat_conn_table.sv
// NAT connection table: hashes a 5-tuple into a linear-probed, direct-indexed table and returns its slot.
// Optional event counters are built only when NAT_CONN_STATS_EN is defined.
module nat_conn_table #(
    parameter int HASH_LEN = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] tuple_data_i,
    input  logic         tuple_valid_i,
    output logic [15:0]  conn_data_o,
    output logic         conn_valid_o,
    output logic         conn_full_o,
    output logic [31:0]  stat_hits_o,
    output logic [31:0]  stat_inserts_o,
    output logic [31:0]  stat_full_o
);
    localparam int DEPTH = 1 << HASH_LEN;
    localparam int KW    = 104;
    localparam int NCH   = (KW + HASH_LEN - 1) / HASH_LEN;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PROBE = 3'd1;
    localparam logic [2:0] S_CMP   = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]          r_state;
    logic [KW-1:0]       r_key;
    logic [HASH_LEN-1:0] r_idx;
    logic [HASH_LEN-1:0] r_probes;
    logic [DEPTH-1:0]    r_vld;
    logic [KW-1:0]       r_mem [DEPTH];
    logic [KW-1:0]       r_rd;
    logic                r_conn_valid;
    logic [HASH_LEN-1:0] r_conn_data;
    logic                r_conn_full;

    logic [NCH*HASH_LEN-1:0] w_kpad;
    logic [HASH_LEN-1:0]     w_hash;
    logic                    w_cmp, w_free, w_eq, w_last;
    logic                    w_ins, w_hit, w_full;
    logic                    w_unused;

    assign w_unused = ^tuple_data_i[127:104];
    assign w_kpad   = (NCH*HASH_LEN)'(tuple_data_i[KW-1:0]);

    always_comb begin
        w_hash = '0;
        for (int c = 0; c < NCH; c++)
            w_hash = w_hash ^ w_kpad[c*HASH_LEN +: HASH_LEN];
    end

    assign w_cmp  = (r_state == S_CMP);
    assign w_free = !r_vld[r_idx];
    assign w_eq   = (r_rd == r_key);
    assign w_last = &r_probes;
    assign w_ins  = w_cmp && w_free;
    assign w_hit  = w_cmp && !w_free && w_eq;
    assign w_full = w_cmp && !w_free && !w_eq && w_last;

    // Key storage: no reset, registered read, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_ins && !reset)
            r_mem[r_idx] <= r_key;
        if (r_state == S_PROBE)
            r_rd <= r_mem[r_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_idx        <= '0;
            r_probes     <= '0;
            r_vld        <= '0;
            r_conn_valid <= 1'b0;
            r_conn_data  <= '0;
            r_conn_full  <= 1'b0;
        end else begin
            r_conn_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (tuple_valid_i) begin
                    r_key    <= tuple_data_i[KW-1:0];
                    r_idx    <= w_hash;
                    r_probes <= '0;
                    r_state  <= S_PROBE;
                end
                S_PROBE: r_state <= S_CMP;
                S_CMP: begin
                    if (w_free || w_eq) begin
                        if (w_free)
                            r_vld[r_idx] <= 1'b1;
                        r_conn_data <= r_idx;
                        r_conn_full <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (w_last) begin
                        r_conn_data <= '0;
                        r_conn_full <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_probes <= r_probes + 1'b1;
                        r_state  <= S_PROBE;
                    end
                end
                S_RESP: begin
                    r_conn_valid <= 1'b1;
                    r_state      <= S_WAIT;
                end
                // Requester keeps tuple_valid_i high until it sees the strobe; don't serve it twice.
                S_WAIT: if (!tuple_valid_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign conn_valid_o = r_conn_valid;
    assign conn_full_o  = r_conn_full;
    assign conn_data_o  = 16'(r_conn_data);

`ifdef NAT_CONN_STATS_EN
    logic [31:0] r_hits, r_inserts, r_fulls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hits    <= '0;
            r_inserts <= '0;
            r_fulls   <= '0;
        end else begin
            if (w_hit)  r_hits    <= r_hits + 32'd1;
            if (w_ins)  r_inserts <= r_inserts + 32'd1;
            if (w_full) r_fulls   <= r_fulls + 32'd1;
        end
    end

    assign stat_hits_o    = r_hits;
    assign stat_inserts_o = r_inserts;
    assign stat_full_o    = r_fulls;
`else
    assign stat_hits_o    = '0;
    assign stat_inserts_o = '0;
    assign stat_full_o    = '0;
`endif

endmodule

// File: tb/tb_nat_conn_table.sv
// Bench for nat_conn_table (HASH_LEN=6): vector table, reset-in-CMP sequence, fill-to-full sequence.
module tb_nat_conn_table;
    localparam int HL = 6;
    localparam int DEPTH = 1 << HL;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] tuple_data_i;
    logic         tuple_valid_i;
    logic [15:0]  conn_data_o;
    logic         conn_valid_o;
    logic         conn_full_o;
    logic [31:0]  stat_hits_o, stat_inserts_o, stat_full_o;

    nat_conn_table #(.HASH_LEN(HL)) dut (
        .clk(clk), .reset(reset),
        .tuple_data_i(tuple_data_i), .tuple_valid_i(tuple_valid_i),
        .conn_data_o(conn_data_o), .conn_valid_o(conn_valid_o), .conn_full_o(conn_full_o),
        .stat_hits_o(stat_hits_o), .stat_inserts_o(stat_inserts_o), .stat_full_o(stat_full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [103:0] key;
        int           exp_idx;
        logic         exp_full;
        int           exp_lat;
        int           hold;
    } vec_t;

    typedef struct {
        int   idx;
        logic full;
        int   lat;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    logic [103:0] mk [DEPTH];
    logic         mv [DEPTH];
    int m_hits, m_ins, m_full;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sx(input int v);
`ifdef NAT_CONN_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic int bhash(input logic [103:0] key);
        int h = 0;
        for (int i = 0; i < 104; i++)
            if (key[i]) h = h ^ (1 << (i % HL));
        return h;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 1'b0;
            mk[i] = '0;
        end
        m_hits = 0; m_ins = 0; m_full = 0;
    endtask

    task automatic model_lookup(input logic [103:0] key, output int idx, output logic full, output int lat);
        int h = bhash(key);
        for (int p = 0; p < DEPTH; p++) begin
            if (!mv[h]) begin
                mv[h] = 1'b1; mk[h] = key; m_ins++;
                idx = h; full = 1'b0; lat = 4 + 2 * p;
                return;
            end
            if (mk[h] == key) begin
                m_hits++;
                idx = h; full = 1'b0; lat = 4 + 2 * p;
                return;
            end
            h = (h + 1) % DEPTH;
        end
        m_full++;
        idx = 0; full = 1'b1; lat = 4 + 2 * (DEPTH - 1);
    endtask

    task automatic do_req(input logic [103:0] key, input int exp_idx, input logic exp_full,
                          input int exp_lat, input int hold);
        exp_t e;
        int   cyc = 0;
        int   extra = 0;
        bit   seen = 0;
        e.idx = exp_idx; e.full = exp_full; e.lat = exp_lat;
        sbq.push_back(e);
        @(negedge clk);
        tuple_data_i  = {24'($urandom), key};
        tuple_valid_i = 1'b1;
        while (!seen && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (conn_valid_o) seen = 1;
        end
        if (!seen) begin
            void'(sbq.pop_front());
            checks++; errors++;
            $display("FAIL resp_timeout: no conn_valid_o within %0d cycles for key %h", cyc, key);
        end else begin
            e = sbq.pop_front();
            chk("conn_data", int'(conn_data_o), e.idx);
            chk("conn_full", int'(conn_full_o), int'(e.full));
            chk("latency", cyc, e.lat);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (conn_valid_o) extra++;
            if (i == 4) tuple_data_i = {24'h0, key ^ 104'h1};
        end
        @(negedge clk);
        tuple_valid_i = 1'b0;
        @(posedge clk); #1;
        if (conn_valid_o) extra++;
        chk("single_pulse", extra, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, int'(conn_valid_o), 0);
        chk({tag, "_full"}, int'(conn_full_o), 0);
        chk({tag, "_data"}, int'(conn_data_o), 0);
        chk({tag, "_hits"}, int'(stat_hits_o), 0);
        chk({tag, "_ins"}, int'(stat_inserts_o), 0);
        chk({tag, "_fulls"}, int'(stat_full_o), 0);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_hits"}, int'(stat_hits_o), sx(m_hits));
        chk({tag, "_ins"}, int'(stat_inserts_o), sx(m_ins));
        chk({tag, "_fulls"}, int'(stat_full_o), sx(m_full));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int   idx, lat, seen;
        logic full;

        vt[0] = '{104'h06,  6, 1'b0, 4, 0};
        vt[1] = '{104'h06,  6, 1'b0, 4, 0};
        vt[2] = '{104'h180, 7, 1'b0, 6, 0};
        vt[3] = '{104'h07,  8, 1'b0, 6, 10};
        vt[4] = '{104'h180, 7, 1'b0, 6, 0};
        vt[5] = '{104'h3F,  63, 1'b0, 4, 0};
        vt[6] = '{104'hFC0, 0, 1'b0, 6, 0};
        vt[7] = '{104'h7F,  62, 1'b0, 4, 0};
        vt[8] = '{104'hFC0, 0, 1'b0, 6, 0};

        reset = 1'b1;
        tuple_valid_i = 1'b0;
        tuple_data_i = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            model_lookup(vt[i].key, idx, full, lat);
            do_req(vt[i].key, vt[i].exp_idx, vt[i].exp_full, vt[i].exp_lat, vt[i].hold);
            if (i == 0) chk_stats("after_first");
            if (i == 1) chk_stats("after_hit");
        end
        chk_stats("table");

        // Reset while the FSM is in CMP for a fresh insert of key 0x0A.
        @(negedge clk);
        tuple_data_i  = {24'h0, 104'h0A};
        tuple_valid_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tuple_valid_i = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (conn_valid_o) seen++;
        end
        chk("reset_cmp_no_resp", seen, 0);
        @(negedge clk);
        chk_idle_outputs("reset2");
        reset = 1'b0;
        model_clear();

        model_lookup(104'h0A, idx, full, lat);
        do_req(104'h0A, idx, full, lat, 0);
        chk("reset_insert_idx", idx, 10);
        chk_stats("post_reset");
        model_lookup(104'h06, idx, full, lat);
        do_req(104'h06, idx, full, lat, 0);
        chk_stats("post_reset_06");

        for (int i = 0; i < DEPTH - 2; i++) begin
            logic [103:0] k;
            k = {32'(i + 1), 72'h0};
            model_lookup(k, idx, full, lat);
            do_req(k, idx, full, lat, 0);
        end
        chk_stats("filled");

        model_lookup(104'hDEAD, idx, full, lat);
        chk("model_full", int'(full), 1);
        do_req(104'hDEAD, idx, full, lat, 0);
        chk_stats("full");
        chk("full_count_exp", m_full, 1);

        model_lookup(104'h0A, idx, full, lat);
        do_req(104'h0A, idx, full, lat, 0);
        chk_stats("hit_when_full");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
